// File: rtl/matrix_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_scan_driver: row-multiplexed LED matrix driver with a pending/display |
// | frame pair swapped only at frame boundaries.  Rev 1.0                        |
// +----------------------------------------------------------------------------+
module matrix_scan_driver #(
  parameter int ROWS  = 8,
  parameter int COLS  = 7,
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [ROWS*COLS-1:0]   frame_in,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [ROWS-1:0]        row_n,
  output logic [COLS-1:0]        col,
  output logic                   frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] c_cnt_max = CW'(DIV - 1);
  localparam logic [CW-1:0] c_blank   = CW'(BLANK);
  localparam logic [RW-1:0] c_row_max = RW'(ROWS - 1);

  logic [CW-1:0]        r_cnt;
  logic [RW-1:0]        r_row;
  logic [ROWS*COLS-1:0] r_disp;
  logic [ROWS*COLS-1:0] r_pending;
  logic                 r_pending_full;
  logic [ROWS-1:0]      r_row_n;
  logic [COLS-1:0]      r_col;
  logic                 r_frame_done;

  logic w_tick;
  logic w_boundary;
  logic w_accept;
  logic w_promote;

  assign w_tick     = enable && (r_cnt == c_cnt_max);
  assign w_boundary = w_tick && (r_row == c_row_max);
  assign w_accept   = frame_valid && !r_pending_full;
  // With the scan stopped there is no tearing to avoid, so promote immediately.
  assign w_promote  = r_pending_full && (w_boundary || !enable);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      r_row          <= '0;
      r_disp         <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_row_n        <= '1;
      r_col          <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      if (!enable) begin
        r_cnt <= '0;
        r_row <= '0;
      end else if (w_tick) begin
        r_cnt <= '0;
        r_row <= (r_row == c_row_max) ? '0 : r_row + RW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_promote) begin
        r_disp <= r_pending;
      end

      if (w_accept) begin
        r_pending      <= frame_in;
        r_pending_full <= 1'b1;
      end else if (w_promote) begin
        r_pending_full <= 1'b0;
      end

      r_frame_done <= w_boundary;

      // Outputs reflect the scan state of the previous cycle.
      if (!enable || (r_cnt < c_blank)) begin
        r_row_n <= '1;
        r_col   <= '0;
      end else begin
        r_row_n <= ~(ROWS'(1) << r_row);
        r_col   <= r_disp[r_row*COLS +: COLS];
      end
    end
  end

  assign frame_ready = !r_pending_full;
  assign row_n       = r_row_n;
  assign col         = r_col;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matrix_scan_driver: directed bench, DIV=4 BLANK=1 ROWS=8 COLS=7.          |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_matrix_scan_driver;

  localparam int ROWS  = 8;
  localparam int COLS  = 7;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = ROWS * DIV;

  logic                 clock;
  logic                 reset_n;
  logic                 enable;
  logic [ROWS*COLS-1:0] frame_in;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [ROWS-1:0]      row_n;
  logic [COLS-1:0]      col;
  logic                 frame_done;

  int checks;
  int errors;
  int ph;

  logic [55:0] f1, fa, fb, fc, fd, fe;

  matrix_scan_driver #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DIV  (DIV),
    .BLANK(BLANK)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .frame_in   (frame_in),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .row_n      (row_n),
    .col        (col),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ph=%0d observed=%h expected=%h", tag, ph, obs, exp);
    end
  endtask

  // One enabled edge: outputs must reflect scan phase ph showing frame d.
  task automatic tick(input logic [55:0] d, input logic exp_ready);
    int c;
    int r;
    logic [7:0] erow;
    logic [6:0] ecol;
    @(posedge clock); #1;
    c = ph % DIV;
    r = (ph / DIV) % ROWS;
    if (c < BLANK) begin
      erow = 8'hFF;
      ecol = 7'h00;
    end else begin
      erow = ~(8'h01 << r);
      ecol = d[r*COLS +: COLS];
    end
    chk("row_n", {56'h0, row_n}, {56'h0, erow});
    chk("col", {57'h0, col}, {57'h0, ecol});
    chk("frame_done", {63'h0, frame_done}, {63'h0, (ph % FRAME) == FRAME - 1});
    chk("frame_ready", {63'h0, frame_ready}, {63'h0, exp_ready});
    ph++;
  endtask

  task automatic tick_off(input logic exp_ready);
    @(posedge clock); #1;
    chk("off_row_n", {56'h0, row_n}, 64'hFF);
    chk("off_col", {57'h0, col}, 64'h0);
    chk("off_frame_done", {63'h0, frame_done}, 64'h0);
    chk("off_frame_ready", {63'h0, frame_ready}, {63'h0, exp_ready});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ph = 0;
    f1 = 56'h55 << 14;
    fa = 56'h0123456789ABCD;
    fb = 56'hFEDCBA98765432;
    fc = 56'h5A5A5A5A5A5A5A;
    fd = 56'hA5A5A5A5A5A5A5;
    fe = 56'h7F7F7F7F7F7F7F;

    reset_n = 1'b1;
    enable = 1'b0;
    frame_valid = 1'b0;
    frame_in = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_row_n", {56'h0, row_n}, 64'hFF);
    chk("rst_col", {57'h0, col}, 64'h0);
    chk("rst_frame_done", {63'h0, frame_done}, 64'h0);
    chk("rst_frame_ready", {63'h0, frame_ready}, 64'h1);
    reset_n = 1'b1;
    enable = 1'b1;

    // Idle scan, two full frames of blank data.
    while (ph < 64) tick('0, 1'b1);

    // Single frame loaded mid-frame (row 3); shows only after the boundary.
    while (ph < 76) tick('0, 1'b1);
    frame_valid = 1'b1;
    frame_in = f1;
    chk("f1_ready_before", {63'h0, frame_ready}, 64'h1);
    tick('0, 1'b0);
    frame_valid = 1'b0;
    frame_in = fe;
    while (ph < 96) tick('0, ph == 95);
    while (ph < 128) tick(f1, 1'b1);

    // Backpressure: A accepted, B held valid until A is promoted.
    frame_valid = 1'b1;
    frame_in = fa;
    tick(f1, 1'b0);
    frame_in = fb;
    while (ph < 160) tick(f1, ph == 159);
    tick(fa, 1'b0);
    frame_valid = 1'b0;
    frame_in = '0;
    while (ph < 192) tick(fa, ph == 191);
    while (ph < 223) tick(fb, 1'b1);

    // Accept on the boundary edge itself: waits one more frame.
    frame_valid = 1'b1;
    frame_in = fc;
    tick(fb, 1'b0);
    frame_valid = 1'b0;
    while (ph < 256) tick(fb, ph == 255);
    while (ph < 288) tick(fc, 1'b1);

    // Enable dropped during row 5 with D pending.
    frame_valid = 1'b1;
    frame_in = fd;
    tick(fc, 1'b0);
    frame_valid = 1'b0;
    while (ph < 310) tick(fc, 1'b0);
    enable = 1'b0;
    repeat (5) tick_off(1'b1);
    enable = 1'b1;
    ph = 0;
    while (ph < 32) tick(fd, 1'b1);

    // Asynchronous reset mid-row-3 with E pending.
    frame_valid = 1'b1;
    frame_in = fe;
    tick(fd, 1'b0);
    frame_valid = 1'b0;
    while (ph < 46) tick(fd, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_row_n", {56'h0, row_n}, 64'hFF);
    chk("arst_col", {57'h0, col}, 64'h0);
    chk("arst_frame_done", {63'h0, frame_done}, 64'h0);
    chk("arst_frame_ready", {63'h0, frame_ready}, 64'h1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    ph = 0;
    while (ph < 32) tick('0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_scan_driver.md
Name: matrix_scan_driver

Overview:
- Consumes the 8x7 LED frame produced by the display source selector and drives the physical LED matrix by row multiplexing.
- Frames arrive as one packed word and are accepted through a valid/ready handshake into a pending buffer.
- A pending frame is promoted to the display buffer only at a frame boundary, so the panel never shows half of one frame and half of another.
- Each row slot starts with a short blanking interval to suppress ghosting.

Parameters:
- ROWS, 8, number of matrix rows.
- COLS, 7, number of matrix columns.
- DIV, 1000, clock cycles per row slot; legal range 2 to 65535.
- BLANK, 2, blanked cycles at the start of each row slot; must satisfy 1 <= BLANK < DIV.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable.
- frame_in  in  ROWS*COLS  packed frame; cell (r,c) is bit r*COLS+c.
- frame_valid  in  1  frame_in holds a frame to load.
- frame_ready  out  1  the driver can accept a frame this cycle.
- row_n  out  ROWS  active-low one-hot row select.
- col  out  COLS  active-high column data for the selected row.
- frame_done  out  1  one-cycle pulse when the scan wraps from the last row to row 0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - cnt=0, row=0, disp=0, pending=0, pending_full=0.
  - Outputs: row_n all ones, col=0, frame_done=0, frame_ready=1.
- Handshake:
  - frame_ready = !pending_full (combinational).
  - On a cycle with frame_valid && frame_ready: pending <= frame_in and pending_full <= 1.
  - frame_in is don't-care when frame_valid is low.
  - Only one frame is ever pending. While pending_full is set, further frames are stalled, not dropped.
- Prescaler and row counter (while enable=1):
  - cnt counts 0..DIV-1. tick is asserted when cnt==DIV-1, and cnt then wraps to 0.
  - On tick, row advances, wrapping from ROWS-1 to 0.
- Frame boundary: a tick with row==ROWS-1.
  - frame_done pulses high for exactly the cycle after that edge.
  - If pending_full=1: disp <= pending and pending_full <= 0 on the same edge.
- A frame accepted on the boundary cycle itself is not promoted then. pending_full was 0 at that edge, so the frame waits one full frame period.
- Accept and promote can never occur on the same edge, because accept requires pending_full=0 and promote requires pending_full=1.
- Outputs are registered, one cycle after the state that produces them:
  - Blank state (cnt < BLANK): row_n <= all ones, col <= 0.
  - Otherwise: row_n <= ~(1<<row), col <= disp[row*COLS +: COLS].
  - At most one row_n bit is ever low.
- enable=0:
  - cnt and row are cleared to 0 synchronously and the outputs are registered blank.
  - frame_done stays 0.
  - A pending frame is promoted to disp on the next edge without waiting for a boundary.
  - The handshake keeps operating normally.
- Re-enable: the scan restarts at row 0, cnt 0, beginning with the blanking interval.
- Reset asserted mid-scan or mid-handshake: all state returns to reset values immediately. A pending frame is discarded.

Test Plan (DIV=4, BLANK=1, ROWS=8, COLS=7 unless stated):
- Reset then hold: after release with enable=1 and no frame, row_n cycles ~01..~80 with each row low for 3 of every 4 cycles, col=0 throughout, and frame_done pulses every 32 cycles.
- Single frame with row 2 = 7'h55 and all other bits 0, loaded mid-frame: disp keeps showing the old frame until the next frame_done. During row 2's unblanked cycles, row_n=8'hFB and col=7'h55.
- Backpressure: send frame A, then hold frame_valid high with frame B. frame_ready stays 0 until A is promoted at the boundary, then B is accepted the following cycle. B appears one frame later and no frame is lost.
- Accept exactly on the boundary cycle: the frame is promoted at the next boundary, 32 cycles later, not the current one.
- enable low for 5 cycles during row 5 with a frame pending: outputs are blank, the frame is promoted during the low period, frame_done stays 0, and the scan restarts at row 0 with a blank cycle.
- Reset asserted mid-row-3 with pending_full=1: all outputs go to reset values asynchronously, and frame_ready=1 after release.
